key_capture_slave: RTL

KEY_CAPTURE_SLAVE -- requirements
Module: key_capture_slave

---
 rtl/key_capture_slave.sv | 137 +++++++++++++
 1 files changed

// File: rtl/key_capture_slave.sv
// Four-key pushbutton capture peripheral: synchronizers, per-key debouncers, Avalon-MM DATA/MASK/EDGE/COUNT registers and a press interrupt.
// Optional macro KEY_PRESS_COUNT_EN adds the 16-bit wrapping press counter at address 3.
module key_capture_slave #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  key_in,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [19:0] TC = 20'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_stable;
  logic [19:0] r_cnt [4];
  logic [3:0]  r_mask;
  logic [3:0]  r_edge;
  logic        r_irq;
  logic [31:0] r_readdata;

  logic [3:0]  w_differ;
  logic [3:0]  w_tc;
  logic [3:0]  w_accept;
  logic [3:0]  w_press;
  logic        w_wr_mask;
  logic        w_wr_edge;
  logic [3:0]  w_edge_clr;
  logic [31:0] w_count_rd;
  logic [31:0] w_rd_mux;

  assign readdata = r_readdata;
  assign irq      = r_irq;

  // Synchronizers reset to the released level so reset release never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_differ = r_sync2 ^ r_stable;
    w_tc     = '0;
    for (int i = 0; i < 4; i++) begin
      w_tc[i] = (r_cnt[i] == TC);
    end
    w_accept = w_differ & w_tc;
    w_press  = w_accept & r_stable;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= 4'hF;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!w_differ[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tc[i]) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 20'd1;
        end
      end
    end
  end

  assign w_wr_mask  = write && (address == 2'd1);
  assign w_wr_edge  = write && (address == 2'd2);
  assign w_edge_clr = w_wr_edge ? writedata[3:0] : 4'h0;

`ifdef KEY_PRESS_COUNT_EN
  logic [15:0] r_count;
  logic [2:0]  w_npress;

  assign w_npress = {2'b00, w_press[0]} + {2'b00, w_press[1]}
                  + {2'b00, w_press[2]} + {2'b00, w_press[3]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (write && (address == 2'd3)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 16'(w_npress);
    end
  end

  assign w_count_rd = {16'h0000, r_count};
`else
  assign w_count_rd = '0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux[3:0] = ~r_stable;
      2'd1:    w_rd_mux[3:0] = r_mask;
      2'd2:    w_rd_mux[3:0] = r_edge;
      default: w_rd_mux      = w_count_rd;
    endcase
  end

  // A press landing in the same cycle as a W1C write wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask     <= '0;
      r_edge     <= '0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      if (w_wr_mask) begin
        r_mask <= writedata[3:0];
      end
      r_edge <= (r_edge & ~w_edge_clr) | w_press;
      r_irq  <= |(r_edge & r_mask);
      if (read) begin
        r_readdata <= w_rd_mux;
      end
    end
  end

endmodule
